// File: rtl/stitch_vfpr_pkg.sv
// Types shared by the vector FP register-file write and read paths.
package stitch_vfpr_pkg;

  localparam int unsigned VfprNumReq    = 2;
  localparam int unsigned VfprAddrWidth = 8;
  localparam int unsigned VfprDataWidth = 64;

  function automatic int unsigned src_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [src_idx_width(VfprNumReq)-1:0] vfpr_src_idx_t;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  typedef struct packed {
    logic [VfprAddrWidth-1:0]   addr;
    logic                       write;
    amo_op_e                    amo;
    logic [VfprDataWidth-1:0]   data;
    logic [VfprDataWidth/8-1:0] strb;
    logic                       user;
  } vfpr_req_chan_t;

  typedef struct packed {
    vfpr_req_chan_t q;
    logic           q_valid;
  } vfpr_req_t;

  typedef struct packed {
    logic q_ready;
    logic p_valid;
  } vfpr_rsp_t;

endpackage

// File: rtl/stitch_vfpr_wr_arbiter_fifo.sv
// In-order tracking queue of granted source indices; occupancy is owned by the parent.
module stitch_vfpr_wr_arbiter_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  T     mem_q [DEPTH];
  ptr_t wr_ptr_q, rd_ptr_q;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/stitch_vfpr_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NumReq writeback
// sources, with grant lock under back-pressure and in-order completion routing.
module stitch_vfpr_wr_arbiter
  import stitch_vfpr_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 8,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         vfpr_req_t     = stitch_vfpr_pkg::vfpr_req_t,
  parameter type         vfpr_rsp_t     = stitch_vfpr_pkg::vfpr_rsp_t
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     req_data_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   req_strb_i,
  output logic [NumReq-1:0]                    ack_o,
  output vfpr_req_t                            wr_port_req_o,
  input  vfpr_rsp_t                            wr_port_rsp_i,
  output logic                                 busy_o
);

  localparam int unsigned IdxW = src_idx_width(NumReq);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  typedef logic [IdxW-1:0] idx_t;
  typedef logic [CntW-1:0] cnt_t;

  idx_t rr_q, lock_q, arb_idx, cand, gnt, head;
  logic lock_valid_q;
  cnt_t count_q, count_d;
  logic full, q_valid, hs, pop;

  assign full    = (count_q == cnt_t'(MaxOutstanding));
  assign q_valid = (|req_valid_i) & ~full;
  assign hs      = q_valid & wr_port_rsp_i.q_ready;
  assign pop     = wr_port_rsp_i.p_valid & (count_q != '0);
  assign gnt     = lock_valid_q ? lock_q : arb_idx;
  assign busy_o  = (count_q != '0);

  // Scan from farthest to nearest offset so the requester closest to rr_q wins last.
  always_comb begin
    arb_idx = rr_q;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = idx_t'((32'(rr_q) + (NumReq - 1 - i)) % NumReq);
      if (req_valid_i[cand]) arb_idx = cand;
    end
  end

  always_comb begin
    wr_port_req_o         = '0;
    wr_port_req_o.q.addr  = req_addr_i[gnt];
    wr_port_req_o.q.data  = req_data_i[gnt];
    wr_port_req_o.q.strb  = req_strb_i[gnt];
    wr_port_req_o.q.write = 1'b1;
    wr_port_req_o.q.amo   = AMONone;
    wr_port_req_o.q.user  = '0;
    wr_port_req_o.q_valid = q_valid;
  end

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[gnt] = 1'b1;
  end

  always_comb begin
    ack_o = '0;
    if (pop) ack_o[head] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (hs && !pop)      count_d = count_q + 1'b1;
    else if (pop && !hs) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= '0;
      lock_q       <= '0;
      lock_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      count_q <= count_d;
      if (hs) begin
        rr_q         <= idx_t'((32'(gnt) + 1) % NumReq);
        lock_valid_q <= 1'b0;
      end else if (q_valid) begin
        lock_valid_q <= 1'b1;
        lock_q       <= gnt;
      end
    end
  end

  stitch_vfpr_wr_arbiter_fifo #(
    .DEPTH (MaxOutstanding),
    .T     (idx_t)
  ) i_track_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (hs),
    .data_i (gnt),
    .pop_i  (pop),
    .data_o (head)
  );

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    wr_port_rsp_i.p_valid |-> (count_q != '0))
    else $warning("p_valid with no write outstanding is ignored");

  for (genvar i = 0; i < NumReq; i++) begin : g_src_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[i] && !req_ready_o[i]) |=>
        (req_valid_i[i] && $stable(req_addr_i[i]) && $stable(req_data_i[i]) &&
         $stable(req_strb_i[i])))
      else $error("source %0d dropped or changed a pending write", i);
  end

endmodule

// File: tb/tb_stitch_vfpr_wr_arbiter.sv
// Directed table-driven bench for stitch_vfpr_wr_arbiter (2 sources, 4 outstanding).
module tb_stitch_vfpr_wr_arbiter;
  import stitch_vfpr_pkg::*;

  localparam logic [7:0]  A0 = 8'h05;
  localparam logic [63:0] D0 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [7:0]  S0 = 8'hFF;
  localparam logic [7:0]  A1 = 8'h3C;
  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [7:0]  S1 = 8'h0F;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][7:0]  req_addr;
  logic [1:0][63:0] req_data;
  logic [1:0][7:0]  req_strb;
  logic [1:0]       ack;
  vfpr_req_t        wr_port_req;
  vfpr_rsp_t        wr_port_rsp;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stitch_vfpr_wr_arbiter #(
    .NumReq         (2),
    .AddrWidth      (8),
    .DataWidth      (64),
    .MaxOutstanding (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .req_strb_i    (req_strb),
    .ack_o         (ack),
    .wr_port_req_o (wr_port_req),
    .wr_port_rsp_i (wr_port_rsp),
    .busy_o        (busy)
  );

  // Row layout: reset pulse, valid[1:0], q_ready, p_valid | q_valid, grant, ready, ack, busy
  typedef struct packed {
    logic       rst;
    logic [1:0] v;
    logic       qr;
    logic       pv;
    logic       qv;
    logic       g;
    logic [1:0] rdy;
    logic [1:0] ack;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare(input vec_t t, input int idx);
    n_vec++;
    check($sformatf("v%0d q_valid", idx), 64'(wr_port_req.q_valid), 64'(t.qv));
    check($sformatf("v%0d ready", idx), 64'(req_ready), 64'(t.rdy));
    check($sformatf("v%0d ack", idx), 64'(ack), 64'(t.ack));
    check($sformatf("v%0d busy", idx), 64'(busy), 64'(t.busy));
    if (t.qv) begin
      check($sformatf("v%0d addr", idx), 64'(wr_port_req.q.addr), 64'(t.g ? A1 : A0));
      check($sformatf("v%0d data", idx), wr_port_req.q.data, t.g ? D1 : D0);
      check($sformatf("v%0d strb", idx), 64'(wr_port_req.q.strb), 64'(t.g ? S1 : S0));
      check($sformatf("v%0d write", idx), 64'(wr_port_req.q.write), 64'd1);
      check($sformatf("v%0d amo", idx), 64'(wr_port_req.q.amo), 64'd0);
      check($sformatf("v%0d user", idx), 64'(wr_port_req.q.user), 64'd0);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(posedge clk);
    #1;
    if (t.rst) begin
      rst_ni = 1'b0;
      #2;
      rst_ni = 1'b1;
    end
    req_valid           = t.v;
    wr_port_rsp.q_ready = t.qr;
    wr_port_rsp.p_valid = t.pv;
    @(negedge clk);
    compare(t, idx);
  endtask

  initial begin
    rst_ni              = 1'b0;
    req_valid           = '0;
    wr_port_rsp.q_ready = 1'b0;
    wr_port_rsp.p_valid = 1'b0;
    req_addr[0] = A0; req_data[0] = D0; req_strb[0] = S0;
    req_addr[1] = A1; req_data[1] = D1; req_strb[1] = S1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    compare(12'b0_00_0_0_0_0_00_00_0, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;

    // single source: accept, idle, completion two cycles later, ack for one cycle only
    tbl.push_back(12'b0_01_1_0_1_0_01_00_0);
    tbl.push_back(12'b0_00_1_0_0_0_00_00_1);
    tbl.push_back(12'b0_00_1_1_0_0_00_01_1);
    tbl.push_back(12'b0_00_1_0_0_0_00_00_0);
    // round-robin 0,1,0,1 from reset, then full with one pop, then drain
    tbl.push_back(12'b1_11_1_0_1_0_01_00_0);
    tbl.push_back(12'b0_11_1_0_1_1_10_00_1);
    tbl.push_back(12'b0_11_1_0_1_0_01_00_1);
    tbl.push_back(12'b0_11_1_0_1_1_10_00_1);
    tbl.push_back(12'b0_11_1_0_0_0_00_00_1);
    tbl.push_back(12'b0_11_1_1_0_0_00_01_1);
    tbl.push_back(12'b0_11_1_0_1_0_01_00_1);
    tbl.push_back(12'b0_10_1_1_0_0_00_10_1);
    tbl.push_back(12'b0_10_1_1_1_1_10_01_1);
    tbl.push_back(12'b0_00_1_1_0_0_00_10_1);
    tbl.push_back(12'b0_00_1_1_0_0_00_01_1);
    tbl.push_back(12'b0_00_1_1_0_0_00_10_1);
    tbl.push_back(12'b0_00_1_0_0_0_00_00_0);
    // back-pressure: source 1 locked for 3 stalled cycles while source 0 waits
    tbl.push_back(12'b0_10_0_0_1_1_00_00_0);
    tbl.push_back(12'b0_11_0_0_1_1_00_00_0);
    tbl.push_back(12'b0_11_0_0_1_1_00_00_0);
    tbl.push_back(12'b0_11_1_0_1_1_10_00_0);
    tbl.push_back(12'b0_01_1_0_1_0_01_00_1);
    tbl.push_back(12'b0_00_1_1_0_0_00_10_1);
    tbl.push_back(12'b0_00_1_1_0_0_00_01_1);
    tbl.push_back(12'b0_00_1_0_0_0_00_00_0);

    foreach (tbl[i]) apply(tbl[i], i + 1);

    // reset with three writes outstanding and the pointer at source 1
    apply(12'b0_01_1_0_1_0_01_00_0, 100);
    apply(12'b0_01_1_0_1_0_01_00_1, 101);
    apply(12'b0_01_1_0_1_0_01_00_1, 102);
    @(posedge clk);
    #1;
    rst_ni              = 1'b0;
    req_valid           = '0;
    wr_port_rsp.p_valid = 1'b0;
    @(negedge clk);
    compare(12'b0_00_1_0_0_0_00_00_0, 103);
    @(posedge clk);
    #1;
    rst_ni              = 1'b1;
    wr_port_rsp.p_valid = 1'b1;
    @(negedge clk);
    compare(12'b0_00_1_1_0_0_00_00_0, 104);
    apply(12'b0_11_1_0_1_0_01_00_0, 105);
    apply(12'b0_10_1_0_1_1_10_00_1, 106);
    apply(12'b0_00_0_0_0_0_00_00_1, 107);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
